// File: rtl/line_mem_responder.sv
// Multi-cycle memory responder for a 256-bit line port: each line access is
// served as 8 single-word beats against 32-bit storage, then done pulses.
module line_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int WORD_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              read_op,
  input  logic              write_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] data_i,
  output logic [LINE_W-1:0] data_o,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int BEATS      = LINE_W / WORD_W;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int OFF_W      = $clog2(LINE_W / 8);
  localparam int IDX_W      = $clog2(DEPTH_WORDS);
  localparam int LINE_IDX_W = IDX_W - BEAT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Handshake: read_op/write_op are levels sampled only in IDLE; write wins
  // when both are high. Requests seen while busy are dropped. done is a
  // one-cycle pulse in DONE; an op still high after that is a new request.

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [LINE_IDX_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]       wdata_q, wdata_d;
  logic [LINE_W-1:0]       buf_q, buf_d;
  logic [LINE_W-1:0]       data_o_q, data_o_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [WORD_W-1:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]        word_idx;
  logic [WORD_W-1:0]       mem_rdata;
  logic [WORD_W-1:0]       mem_wdata;
  logic                    mem_we;
  logic                    last_beat;
  logic                    unused_addr;

  // Only the line-index bits that reach the storage are kept; higher
  // address bits wrap by construction.
  assign word_idx    = {line_q, beat_q};
  assign mem_rdata   = mem[word_idx];
  assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));
  assign unused_addr = ^{addr[ADDR_W-1:OFF_W+LINE_IDX_W], addr[OFF_W-1:0]};

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    data_o_d  = data_o_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = wdata_q[beat_q*WORD_W +: WORD_W];

    case (state_q)
      ST_IDLE: begin
        if (write_op) begin
          state_d = ST_WR;
          line_d  = addr[OFF_W +: LINE_IDX_W];
          wdata_d = data_i;
          beat_d  = '0;
          busy_d  = 1'b1;
        end else if (read_op) begin
          state_d = ST_RD;
          line_d  = addr[OFF_W +: LINE_IDX_W];
          beat_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_WR: begin
        mem_we = 1'b1;
        beat_d = beat_q + BEAT_W'(1);
        if (last_beat) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_RD: begin
        buf_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
        beat_d = beat_q + BEAT_W'(1);
        if (last_beat) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          // Whole line published at once so the core never sees a partial line.
          data_o_d = buf_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        beat_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      line_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      data_o_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      data_o_q <= data_o_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Storage survives reset; an aborted write keeps the beats it completed.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[word_idx] <= mem_wdata;
    end
  end

  assign data_o    = data_o_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: word-level reference memory, expected read
// lines queued at request time and compared when done pulses.
module tb_line_mem_responder;

  localparam int W = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          read_op = 1'b0;
  logic          write_op = 1'b0;
  logic [31:0]   addr = '0;
  logic [W-1:0]  data_i = '0;
  logic [W-1:0]  data_o;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  // clock / reset
  always #5 CLK = ~CLK;

  line_mem_responder dut (
    .CLK       (CLK),
    .RST       (RST),
    .read_op   (read_op),
    .write_op  (write_op),
    .addr      (addr),
    .data_i    (data_i),
    .data_o    (data_o),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  model_mem [int];
  logic [W-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a, input int k);
    logic [31:0] t;
    t = ((a >> 5) << 3) + 32'(k);
    return int'(t % 32'd1024);
  endfunction

  function automatic logic [W-1:0] model_line(input logic [31:0] a);
    logic [W-1:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = model_mem[widx(a, k)];
    return l;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [W-1:0] d);
    for (int k = 0; k < 8; k++) model_mem[widx(a, k)] = d[32*k +: 32];
  endtask

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // driver: presents a request for one edge, then scrambles don't-care inputs
  task automatic drive_op(input bit is_wr, input bit both, input logic [31:0] a,
                          input logic [W-1:0] d);
    @(negedge CLK);
    write_op = is_wr;
    read_op  = !is_wr || both;
    addr     = a;
    data_i   = d;
    if (is_wr) model_write(a, d);
    else exp_q.push_back(model_line(a));
    @(negedge CLK);
    write_op = 1'b0;
    read_op  = 1'b0;
    addr     = $urandom;
    data_i   = rand_line();
  endtask

  // Called at the first negedge after the accept edge.
  task automatic wait_done(input bit is_rd, input string tag);
    int  busy_cnt;
    bit  seen;
    logic [W-1:0] exp;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        check({tag, "_lat"}, W'(n), W'(8));
        if (is_rd) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          check({tag, "_data"}, data_o, exp);
          last_rd = exp;
        end else begin
          check({tag, "_hold"}, data_o, last_rd);
        end
        break;
      end
      @(negedge CLK);
    end
    if (!seen) begin
      check({tag, "_timeout"}, W'(0), W'(1));
    end else begin
      @(negedge CLK);
      check({tag, "_busy_cnt"}, W'(busy_cnt), W'(9));
      check({tag, "_idle"}, {busy, done}, 2'b00);
    end
  endtask

  task automatic run_op(input bit is_wr, input bit both, input logic [31:0] a,
                        input logic [W-1:0] d, input string tag);
    drive_op(is_wr, both, a, d);
    wait_done(!is_wr, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p;
    logic [W-1:0] exp;
    logic [31:0]  a;
    int           ndone;

    // 1) reset
    #2;
    check("rst_data_o", data_o, '0);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_state", W'(dbg_state), W'(0));
    @(negedge CLK);
    RST = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("idle_quiet", {busy, done}, 2'b00);
    end

    // 2) write then read a line
    p = 256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000;
    run_op(1'b1, 1'b0, 32'h40, p, "wr40");
    run_op(1'b0, 1'b0, 32'h40, '0, "rd40");

    // 3) both ops high: write wins, data_o untouched
    run_op(1'b1, 1'b1, 32'h20, {32{8'hA5}}, "both");
    run_op(1'b0, 1'b0, 32'h20, '0, "both_rd");

    // 4) address wrap past DEPTH_WORDS
    p = rand_line();
    run_op(1'b1, 1'b0, 32'h1000, p, "wrap_wr");
    run_op(1'b0, 1'b0, 32'h0, '0, "wrap_rd");

    // 5) reset in the middle of a write
    run_op(1'b1, 1'b0, 32'h80, '0, "abort_pre");
    @(negedge CLK);
    write_op = 1'b1;
    addr     = 32'h80;
    data_i   = {W{1'b1}};
    @(negedge CLK);
    write_op = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_data_o", data_o, '0);
    check("abort_state", W'(dbg_state), W'(0));
    for (int k = 0; k < 4; k++) model_mem[widx(32'h80, k)] = 32'hFFFF_FFFF;
    last_rd = '0;
    @(negedge CLK);
    RST = 1'b1;
    run_op(1'b0, 1'b0, 32'h80, '0, "abort_rd");

    // 6a) read pulse during a write is ignored
    p = rand_line();
    @(negedge CLK);
    write_op = 1'b1;
    addr     = 32'h100;
    data_i   = p;
    model_write(32'h100, p);
    @(negedge CLK);
    write_op = 1'b0;
    ndone = 0;
    for (int n = 0; n < 14; n++) begin
      if (done) ndone++;
      if (n == 2) read_op = 1'b1;
      if (n == 5) read_op = 1'b0;
      @(negedge CLK);
    end
    check("busy_req_dones", W'(ndone), W'(1));
    check("busy_req_hold", data_o, last_rd);
    check("busy_req_idle", W'(busy), W'(0));

    // 6b) read held through done is re-accepted as a second read
    @(negedge CLK);
    read_op = 1'b1;
    addr    = 32'h100;
    exp_q.push_back(model_line(32'h100));
    exp_q.push_back(model_line(32'h100));
    @(negedge CLK);
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) check("hold_first_lat", W'(n), W'(8));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("hold_rd_data", data_o, exp);
        last_rd = exp;
      end
      if (n == 10) read_op = 1'b0;
      @(negedge CLK);
    end
    check("hold_dones", W'(ndone), W'(2));
    check("hold_idle", W'(busy), W'(0));

    // random write/read pairs
    for (int i = 0; i < 4; i++) begin
      a = (32'($urandom_range(0, 63)) << 5) | 32'($urandom_range(0, 31));
      run_op(1'b1, 1'b0, a, rand_line(), "rnd_wr");
      run_op(1'b0, 1'b0, a, '0, "rnd_rd");
    end

    check("queue_empty", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
